// File: rtl/parport_rx.sv
`default_nettype none
// ============================================================================
// Module   : parport_rx
// Purpose  : Odd-parity parallel print port receiver. Synchronises the sender
//            strobe, captures the 9-bit port, checks parity, buffers bytes in
//            a first-word fall-through FIFO and returns a four-phase ack,
//            withholding the ack while the FIFO is full.
// Revision : 1.0 - initial release
// ============================================================================
module parport_rx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int ACK_DELAY   = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DROP_BAD    = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          strobe,
  input  logic [8:0]                    din,
  output logic                          ack,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_data,
  output logic                          out_perr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   perr_count,
  output logic                          proto_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(ACK_DELAY) + 1;
  localparam logic [CW-1:0] c_DEPTH    = CW'(FIFO_DEPTH);
  localparam logic [DW-1:0] c_DLY_LOAD = DW'(ACK_DELAY - 1);
  localparam logic          c_DROP     = (DROP_BAD != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CAPT = 2'd1,
    S_DLY  = 2'd2,
    S_ACKH = 2'd3
  } state_t;

  state_t                 r_state;
  logic [DW-1:0]          r_dly;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_strobe_d;
  logic                   r_armed;
  logic [8:0]             r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr;
  logic [AW-1:0]          r_rd;

  logic w_strobe_s;
  logic w_rise;
  logic w_perr;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_strobe_s = r_sync[SYNC_STAGES-1];
  // A rise only counts once strobe has been seen low after reset, so a strobe
  // left high across reset is not mistaken for a new transfer.
  assign w_rise     = w_strobe_s & ~r_strobe_d & r_armed;
  assign w_perr     = ~(^din);
  assign w_full     = (fifo_count == c_DEPTH);
  assign w_push     = (r_state == S_CAPT) && w_strobe_s && !w_full && !(c_DROP && w_perr);
  assign w_pop      = out_valid && out_ready;

  assign out_valid  = (fifo_count != '0);
  assign out_data   = out_valid ? r_mem[r_rd][7:0] : 8'h00;
  assign out_perr   = out_valid ? r_mem[r_rd][8]   : 1'b0;

  // Strobe synchroniser; r_fill marks when the chain holds a real sample.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync     <= '0;
      r_fill     <= '0;
      r_strobe_d <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_sync[0] <= strobe;
      r_fill[0] <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
        r_fill[i] <= r_fill[i-1];
      end
      r_strobe_d <= w_strobe_s;
      if (r_fill[SYNC_STAGES-1] && !w_strobe_s) begin
        r_armed <= 1'b1;
      end
    end
  end

  // Handshake FSM: capture, ack delay, ack hold, protocol error detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_dly      <= '0;
      ack        <= 1'b0;
      perr_count <= 16'h0000;
      proto_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state <= S_CAPT;
          end
        end
        S_CAPT: begin
          if (!w_strobe_s) begin
            proto_err <= 1'b1;
            r_state   <= S_IDLE;
          end else if (!w_full) begin
            if (w_perr && (perr_count != 16'hFFFF)) begin
              perr_count <= perr_count + 16'd1;
            end
            r_dly   <= c_DLY_LOAD;
            r_state <= S_DLY;
          end
        end
        S_DLY: begin
          if (!w_strobe_s) begin
            proto_err <= 1'b1;
            r_state   <= S_IDLE;
          end else if (r_dly == '0) begin
            ack     <= 1'b1;
            r_state <= S_ACKH;
          end else begin
            r_dly <= r_dly - 1'b1;
          end
        end
        S_ACKH: begin
          if (!w_strobe_s) begin
            ack     <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count as is.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr       <= '0;
      r_rd       <= '0;
      fifo_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage; contents need no reset since out_valid gates the head.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= {w_perr, din[7:0]};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_parport_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_parport_rx
// Purpose  : Self-checking bench for parport_rx with a queue-based reference
//            model of the byte stream, parity error count and handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parport_rx;

  logic       clk = 1'b0;
  logic       reset, strobe, strobe2, out_ready, out_ready2;
  logic [8:0] din, din2;
  logic       ack, out_valid, out_perr, proto_err;
  logic       ack2, out_valid2, out_perr2, proto_err2;
  logic [7:0] out_data, out_data2;
  logic [3:0] fifo_count, fifo_count2;
  logic [15:0] perr_count, perr_count2;

  always #5 clk = ~clk;

  parport_rx dut (
    .clk(clk), .reset(reset), .strobe(strobe), .din(din), .ack(ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_perr(out_perr), .fifo_count(fifo_count), .perr_count(perr_count),
    .proto_err(proto_err)
  );

  parport_rx #(.FIFO_DEPTH(8), .ACK_DELAY(4), .SYNC_STAGES(2), .DROP_BAD(1)) dut2 (
    .clk(clk), .reset(reset), .strobe(strobe2), .din(din2), .ack(ack2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_perr(out_perr2), .fifo_count(fifo_count2), .perr_count(perr_count2),
    .proto_err(proto_err2)
  );

  int         nvec = 0;
  int         nfail = 0;
  logic [8:0] q[$];
  int         exp_perr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Parity error when the 9-bit word holds an even number of ones.
  function automatic logic bad_par(input logic [8:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  function automatic logic [8:0] good(input logic [7:0] b);
    logic [8:0] d;
    d = {1'b0, b};
    if (($countones(d) % 2) == 0) d[8] = 1'b1;
    return d;
  endfunction

  function automatic logic sel_ack(input bit sel);
    return sel ? ack2 : ack;
  endfunction

  task automatic wait_ack(input bit sel, input logic val, input string tag, output int lat);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      if (sel_ack(sel) === val) break;
      tick();
      lat = k;
    end
    check(tag, {31'd0, sel_ack(sel)}, {31'd0, val});
  endtask

  task automatic send(input bit sel, input logic [8:0] d, output int lat);
    int l2;
    if (sel) begin din2 = d; strobe2 = 1'b1; end
    else     begin din  = d; strobe  = 1'b1; end
    wait_ack(sel, 1'b1, "ack_rise", lat);
    if (sel) strobe2 = 1'b0; else strobe = 1'b0;
    wait_ack(sel, 1'b0, "ack_fall", l2);
    if (!sel) begin
      q.push_back({bad_par(d), d[7:0]});
      if (bad_par(d)) exp_perr++;
    end
  endtask

  task automatic pop_check(input string tag);
    logic [8:0] e;
    e = q.pop_front();
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"},  {24'd0, out_data}, {24'd0, e[7:0]});
    check({tag, "_perr"},  {31'd0, out_perr}, {31'd0, e[8]});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         lat;
    logic [8:0] d;
    bit         saw_ack;

    reset = 1'b0; strobe = 1'b0; strobe2 = 1'b0;
    out_ready = 1'b0; out_ready2 = 1'b0; din = '0; din2 = '0;
    repeat (3) tick();
    check("rst_ack",        {31'd0, ack}, 32'd0);
    check("rst_valid",      {31'd0, out_valid}, 32'd0);
    check("rst_data",       {24'd0, out_data}, 32'd0);
    check("rst_count",      {28'd0, fifo_count}, 32'd0);
    check("rst_perr_count", {16'd0, perr_count}, 32'd0);
    check("rst_proto",      {31'd0, proto_err}, 32'd0);
    reset = 1'b1;
    repeat (8) tick();

    // Good byte: latency = synchroniser + rise register + capture + ACK_DELAY.
    send(1'b0, 9'h141, lat);
    check("t1_latency",    lat, 32'd2 + 32'd1 + 32'd1 + 32'd2);
    check("t1_count",      {28'd0, fifo_count}, 32'd1);
    check("t1_perr_count", {16'd0, perr_count}, 32'd0);
    pop_check("t1");
    check("t1_proto",      {31'd0, proto_err}, 32'd0);

    // Bad parity kept with flag.
    send(1'b0, 9'h041, lat);
    check("t2_perr_count", {16'd0, perr_count}, exp_perr);
    pop_check("t2");

    // Bad parity dropped on the DROP_BAD instance.
    send(1'b1, 9'h041, lat);
    check("t2_drop_count", {28'd0, fifo_count2}, 32'd0);
    check("t2_drop_perr",  {16'd0, perr_count2}, 32'd1);

    // Pop request while empty does nothing.
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    check("t2_empty_pop_count", {28'd0, fifo_count}, 32'd0);
    check("t2_empty_pop_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: fill, ninth byte withheld until a pop frees a slot.
    for (int i = 1; i <= 8; i++) send(1'b0, good(8'(i)), lat);
    check("t3_full_count", {28'd0, fifo_count}, 32'd8);
    din = good(8'd9); strobe = 1'b1;
    repeat (20) tick();
    check("t3_backpressure_ack",   {31'd0, ack}, 32'd0);
    check("t3_backpressure_count", {28'd0, fifo_count}, 32'd8);
    pop_check("t3_first");
    wait_ack(1'b0, 1'b1, "t3_ack_after_pop", lat);
    q.push_back({1'b0, 8'd9});
    strobe = 1'b0;
    wait_ack(1'b0, 1'b0, "t3_ack_fall", lat);
    check("t3_refill_count", {28'd0, fifo_count}, 32'd8);
    for (int i = 0; i < 8; i++) pop_check("t3_order");

    // Push and pop on the same edge at count 3.
    for (int i = 0; i < 3; i++) send(1'b0, good(8'(8'hA0 + i)), lat);
    din = good(8'h5C); strobe = 1'b1;
    repeat (3) tick();
    check("t4_head", {24'd0, out_data}, {24'd0, q[0][7:0]});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    void'(q.pop_front());
    q.push_back({1'b0, 8'h5C});
    check("t4_same_edge_count", {28'd0, fifo_count}, 32'd3);
    wait_ack(1'b0, 1'b1, "t4_ack_rise", lat);
    strobe = 1'b0;
    wait_ack(1'b0, 1'b0, "t4_ack_fall", lat);

    // Random traffic through the pointer wrap, against the queue model.
    for (int i = 0; i < 24; i++) begin
      d = 9'($urandom_range(0, 511));
      if (q.size() == 8) pop_check("rnd_pre");
      send(1'b0, d, lat);
      check("rnd_count",      {28'd0, fifo_count}, q.size());
      check("rnd_perr_count", {16'd0, perr_count}, exp_perr);
      if ($urandom_range(0, 1) == 1 && q.size() > 0) pop_check("rnd");
    end
    while (q.size() > 0) pop_check("rnd_drain");

    // Strobe dropped during the ack delay.
    din2 = 9'h0AB; strobe2 = 1'b1;
    for (int k = 0; k < 40 && fifo_count2 != 4'd1; k++) tick();
    check("t5_captured", {28'd0, fifo_count2}, 32'd1);
    strobe2 = 1'b0;
    saw_ack = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ack2 === 1'b1) saw_ack = 1'b1;
    end
    check("t5_no_ack",  {31'd0, saw_ack}, 32'd0);
    check("t5_proto",   {31'd0, proto_err2}, 32'd1);
    check("t5_count",   {28'd0, fifo_count2}, 32'd1);
    check("t5_data",    {24'd0, out_data2}, 32'hAB);
    check("t5_perr",    {31'd0, out_perr2}, 32'd0);

    // Reset mid-handshake with bytes queued; strobe held high across release.
    for (int i = 0; i < 4; i++) send(1'b0, good(8'(8'h30 + i)), lat);
    din = good(8'h77); strobe = 1'b1;
    wait_ack(1'b0, 1'b1, "t6_ack_before_reset", lat);
    reset = 1'b0;
    tick();
    check("t6_ack",    {31'd0, ack}, 32'd0);
    check("t6_count",  {28'd0, fifo_count}, 32'd0);
    check("t6_valid",  {31'd0, out_valid}, 32'd0);
    check("t6_proto",  {31'd0, proto_err2 & 1'b0 | proto_err}, 32'd0);
    check("t6_proto2", {31'd0, proto_err2}, 32'd0);
    q.delete();
    exp_perr = 0;
    reset = 1'b1;
    repeat (30) tick();
    check("t6_no_spurious_ack",   {31'd0, ack}, 32'd0);
    check("t6_no_spurious_count", {28'd0, fifo_count}, 32'd0);
    strobe = 1'b0;
    repeat (5) tick();
    send(1'b0, good(8'hC3), lat);
    check("t6_after_count", {28'd0, fifo_count}, 32'd1);
    pop_check("t6_after");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
